// File: rtl/commit_event_tx.sv
// rtl/commit_event_tx.sv - retire FIFO replaying ROB entries as one-cycle commit events
// Optional macro COMMIT_TX_BYPASS_EN: an entry arriving at an empty FIFO goes straight to the output register.
module commit_event_tx #(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  in_type_i,
  input  logic [31:0] in_pc_i,
  input  logic [4:0]  in_rd1_i,
  input  logic [4:0]  in_rd2_i,
  input  logic [31:0] in_data1_i,
  input  logic [31:0] in_data2_i,
  input  logic [31:0] in_addr_i,
  input  logic [1:0]  in_store_type_i,
  input  logic        in_mispredict_i,
  input  logic        tx_hold_i,
  output logic        WB_en1_o,
  output logic        WB_en2_o,
  output logic        load_en_o,
  output logic        store_en_o,
  output logic        branch_en_o,
  output logic        jump_en_o,
  output logic        flush_en_o,
  output logic [4:0]  WB_target1_o,
  output logic [4:0]  WB_target2_o,
  output logic [31:0] WB_data1_o,
  output logic [31:0] WB_data2_o,
  output logic [31:0] store_addr_o,
  output logic [31:0] store_value_o,
  output logic [31:0] branch_target_pc_o,
  output logic [31:0] jump_target_pc_o,
  output logic [31:0] ins_pc_o,
  output logic [1:0]  store_type_o,
  output logic        rob_full_o,
  output logic        bad_type_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] T_WRITE  = 3'd0;
  localparam logic [2:0] T_WRITE2 = 3'd1;
  localparam logic [2:0] T_STORE  = 3'd2;
  localparam logic [2:0] T_BRANCH = 3'd3;
  localparam logic [2:0] T_JUMP   = 3'd4;
  localparam logic [2:0] T_LOAD   = 3'd5;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] addr;
    logic [1:0]  st;
    logic        mp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  // Strobe order: wb1, wb2, load, store, branch, jump, flush, bad
  logic [7:0]      strb_q, strb_d;
  logic [4:0]      wb_t1_q, wb_t2_q;
  logic [31:0]     wb_d1_q, wb_d2_q, st_addr_q, st_val_q, br_tgt_q, jp_tgt_q, pc_q;
  logic [1:0]      st_type_q;
  logic [31:0]     wb_d1_d;

  entry_t in_entry, src;
  logic   push, byp, fifo_wr, fifo_pop, emit;

  assign in_entry = {in_type_i, in_pc_i, in_rd1_i, in_rd2_i, in_data1_i, in_data2_i,
                     in_addr_i, in_store_type_i, in_mispredict_i};

  assign in_ready_o = (count_q < FULL);
  assign rob_full_o = (count_q == FULL);
  assign push       = in_valid_i && in_ready_o;

`ifdef COMMIT_TX_BYPASS_EN
  assign byp = push && (count_q == '0) && !tx_hold_i;
`else
  assign byp = 1'b0;
`endif

  assign fifo_pop = (count_q != '0) && !tx_hold_i;
  assign fifo_wr  = push && !byp;
  assign emit     = fifo_pop || byp;
  assign src      = byp ? in_entry : mem_q[rd_ptr_q];
  assign count_d  = count_q + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_pop};

  always_comb begin
    strb_d  = 8'h00;
    wb_d1_d = src.d1;
    if (src.typ == T_JUMP) wb_d1_d = src.pc + 32'd4;
    if (emit) begin
      case (src.typ)
        T_WRITE:  strb_d[7] = (src.rd1 != 5'd0);
        T_WRITE2: begin
          strb_d[7] = (src.rd1 != 5'd0);
          strb_d[6] = (src.rd2 != 5'd0);
        end
        T_LOAD: begin
          strb_d[7] = (src.rd1 != 5'd0);
          strb_d[5] = 1'b1;
        end
        T_STORE:  strb_d[4] = 1'b1;
        T_BRANCH: begin
          strb_d[3] = 1'b1;
          strb_d[1] = src.mp;
        end
        T_JUMP: begin
          strb_d[2] = 1'b1;
          strb_d[7] = (src.rd1 != 5'd0);
        end
        default:  strb_d[0] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      strb_q    <= '0;
      wb_t1_q   <= '0;
      wb_t2_q   <= '0;
      wb_d1_q   <= '0;
      wb_d2_q   <= '0;
      st_addr_q <= '0;
      st_val_q  <= '0;
      st_type_q <= '0;
      br_tgt_q  <= '0;
      jp_tgt_q  <= '0;
      pc_q      <= '0;
    end else begin
      count_q <= count_d;
      strb_q  <= strb_d;
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Data fields hold between events; only an emission reloads them.
      if (emit) begin
        wb_t1_q   <= src.rd1;
        wb_t2_q   <= src.rd2;
        wb_d1_q   <= wb_d1_d;
        wb_d2_q   <= src.d2;
        st_addr_q <= src.addr;
        st_val_q  <= src.d1;
        st_type_q <= src.st;
        br_tgt_q  <= src.d1;
        jp_tgt_q  <= src.d1;
        pc_q      <= src.pc;
      end
    end
  end

  assign WB_en1_o           = strb_q[7];
  assign WB_en2_o           = strb_q[6];
  assign load_en_o          = strb_q[5];
  assign store_en_o         = strb_q[4];
  assign branch_en_o        = strb_q[3];
  assign jump_en_o          = strb_q[2];
  assign flush_en_o         = strb_q[1];
  assign bad_type_o         = strb_q[0];
  assign WB_target1_o       = wb_t1_q;
  assign WB_target2_o       = wb_t2_q;
  assign WB_data1_o         = wb_d1_q;
  assign WB_data2_o         = wb_d2_q;
  assign store_addr_o       = st_addr_q;
  assign store_value_o      = st_val_q;
  assign store_type_o       = st_type_q;
  assign branch_target_pc_o = br_tgt_q;
  assign jump_target_pc_o   = jp_tgt_q;
  assign ins_pc_o           = pc_q;

endmodule

// File: doc/commit_event_tx.md
# commit_event_tx

Transmit side of the commit-event interface. Accepts retiring instructions from the ROB head one per cycle, buffers them in a small FIFO, and replays each as a one-cycle commit event (writeback, load, store, branch, jump) on the same signal set the commit checker consumes. It sits between the ROB retire port and the commit checker, and drives `rob_full` as back-pressure status.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  retire entry present
- `in_ready`  out  1  entry accepted when `in_valid && in_ready`
- `in_type`  in  3  0=WRITE, 1=WRITE2, 2=STORE, 3=BRANCH, 4=JUMP, 5=LOAD; 6/7 illegal
- `in_pc`  in  32  instruction PC
- `in_rd1`, `in_rd2`  in  5  destination registers
- `in_data1`, `in_data2`  in  32  result data / target PC / store value
- `in_addr`  in  32  store address
- `in_store_type`  in  2  store width code
- `in_mispredict`  in  1  branch was mispredicted
- `tx_hold`  in  1  suppress emission this cycle
- `WB_en1`, `WB_en2`, `load_en`, `store_en`, `branch_en`, `jump_en`, `flush_en`  out  1  event strobes
- `WB_target1`, `WB_target2`  out  5
- `WB_data1`, `WB_data2`, `store_addr`, `store_value`, `branch_target_pc`, `jump_target_pc`, `ins_pc`  out  32
- `store_type`  out  2
- `rob_full`  out  1  FIFO occupancy == DEPTH
- `bad_type`  out  1  one-cycle pulse for an illegal entry

## Operation
- FIFO with a `log2(DEPTH)+1`-bit occupancy count; read and write pointers wrap modulo DEPTH.
- `in_ready = (count < DEPTH)`. No pass-through on full.
- Pop: one entry per cycle when `count > 0` and `!tx_hold`. The popped entry loads the output register.
- Decode at pop:
  - WRITE: `WB_en1` = (rd1 != 0); target rd1, data1.
  - WRITE2: as WRITE, plus `WB_en2` = (rd2 != 0) with rd2/data2.
  - LOAD: `load_en` = 1; `WB_en1` as for WRITE.
  - STORE: `store_en` = 1; `store_addr` = addr, `store_value` = data1, `store_type` = in_store_type.
  - BRANCH: `branch_en` = 1; `branch_target_pc` = data1; `flush_en` = in_mispredict (same cycle).
  - JUMP: `jump_en` = 1; `jump_target_pc` = data1; `WB_en1` = (rd1 != 0); `WB_data1` = pc + 4 (32-bit wrap).
  - 6/7: no strobes; `bad_type` = 1.
- `ins_pc` = entry PC for every emitted event.
- Strobes deassert in any cycle with no pop. Data outputs then hold their last values.
- Order is strictly FIFO; no entry is dropped except by reset.

## Timing
- Reset: all outputs 0, `in_ready` = 1 (DEPTH > 0), count 0, pointers 0. Reset mid-stream discards all queued entries. `rst` has priority over push, pop and hold.
- Entry handshaken in cycle C is written to the FIFO at the end of C. The earliest emission is cycle C+2 (pop at end of C+1, registered outputs).
- Each entry produces exactly one strobe cycle.
- Simultaneous push and pop leaves count unchanged. A push in the same cycle as a pop from a full FIFO is refused, since `in_ready` was 0.
- `tx_hold` high: no pop, all strobes 0 that cycle; pushes still accepted while not full.
- `rob_full` is combinational from count: high exactly when count == DEPTH.

## Configuration
- `COMMIT_TX_BYPASS_EN` defined: when count == 0, `!tx_hold` and a handshake occur in cycle C, the entry loads the output register directly, skips the FIFO, and is emitted in cycle C+1. Ordering is preserved because bypass applies only when the FIFO is empty.
- Undefined: every entry passes through the FIFO, with a latency of 2 cycles minimum.

## Test plan
- Reset, then WRITE pc=0x100 rd1=5 data1=0xDEADBEEF in cycle 0 -> cycle 2: `WB_en1`=1, `WB_target1`=5, `WB_data1`=0xDEADBEEF, `ins_pc`=0x100, other strobes 0. With `COMMIT_TX_BYPASS_EN` the same event appears in cycle 1.
- JUMP pc=0xFFFFFFFC rd1=1 data1=0x200 -> `jump_en`=1, `jump_target_pc`=0x200, `WB_en1`=1, `WB_data1`=0x00000000 (wrap). WRITE with rd1=0 -> no `WB_en1`.
- BRANCH data1=0x400 mispredict=1, followed by BRANCH mispredict=0 -> first event: `branch_en`=`flush_en`=1 in the same cycle; second: `branch_en`=1, `flush_en`=0.
- Hold `tx_hold`=1 and push 9 entries (DEPTH=8) -> `rob_full`=1 and `in_ready`=0 after 8; the 9th stalls. Release hold -> 8 events on consecutive cycles in order, then the 9th.
- Continuous push and pop at one per cycle for 20 entries -> count stays constant, pointers wrap, and the event order matches the input order.
- Push type 6 between two STOREs, then assert `rst` with 3 entries queued -> `bad_type` pulses once with no strobes; after reset no further events and all outputs 0.
